dpbuf_fifo: RTL
===============

DPBUF_FIFO -- requirements
Module: dpbuf_fifo

Interface
REQ-001 SHALL have parameter ADDR_WDTH, default 4; memory address width, MEM_SIZE = 2**ADDR_WDTH.
REQ-002 SHALL have parameter DATA_WDTH, default 8; data word width.
REQ-003 SHALL have port clk  in  1  single clock; all logic on posedge clk.
REQ-004 SHALL have port sync_reset  in  1  reset, synchronous to clk, active-high.
REQ-005 SHALL have port in_data  in  DATA_WDTH  write data.
REQ-006 SHALL have port in_val  in  1  write request.
REQ-007 SHALL have port in_rdy  out  1  space available; a word is accepted when in_val && in_rdy.
REQ-008 SHALL have port out_data  out  DATA_WDTH  head-of-queue data.
REQ-009 SHALL have port out_val  out  1  out_data holds a valid word.
REQ-010 SHALL have port out_rdy  in  1  consumer accept; a word is popped when out_val && out_rdy.
REQ-011 SHALL have port level  out  ADDR_WDTH+2  total words held (memory + in-flight + output stage).
REQ-012 SHALL have port empty  out  1  level == 0.

Function
REQ-013 SHALL store words in one dpbuf_mem instance, with both of its clocks tied to clk.
REQ-014 SHALL keep wr_ptr and rd_ptr of ADDR_WDTH+1 bits; memory address = low ADDR_WDTH bits; both wrap modulo 2*MEM_SIZE.
REQ-015 SHALL compute mem_count = wr_ptr - rd_ptr (ADDR_WDTH+1 bits, modulo arithmetic).
REQ-016 SHALL drive in_rdy = (mem_count != MEM_SIZE), from registered state only, with no combinational path from out_rdy.
REQ-017 SHALL, on accept, write in_data to mem[wr_ptr] and increment wr_ptr in the same cycle.
REQ-018 SHALL hold a 2-entry output queue (oq) plus an inflight flag for the 1-cycle memory read latency.
REQ-019 SHALL assert mem rd_en in a cycle iff mem_count != 0 and (oq_count + inflight - pop) < 2; rd_ptr increments on rd_en.
REQ-020 SHALL push rd_dout into the oq tail when rd_dout_val is 1, in the same cycle as any pop from the head.
REQ-021 SHALL drive out_val = (oq_count != 0) and out_data = oq head, both registered.
REQ-022 SHALL give first-word latency: word accepted in cycle N into an empty FIFO -> out_val=1 in cycle N+3.
REQ-023 SHALL sustain one word per cycle in and out in steady state when out_rdy is held high.
REQ-024 SHALL drop a write issued while in_rdy=0, leaving pointers and level unchanged; this SHALL hold even if a read is issued in the same cycle.
REQ-025 SHALL count level = mem_count + inflight + oq_count; maximum = MEM_SIZE + 2.
REQ-026 SHALL keep out_data stable while out_val=1 and out_rdy=0.
REQ-027 SHALL handle a simultaneous accept and pop with level unchanged and no lost or duplicated words.

Reset
REQ-028 SHALL, on sync_reset=1 at posedge clk, clear wr_ptr, rd_ptr, inflight and oq_count.
REQ-029 SHALL give reset output values: out_val=0, empty=1, level=0, in_rdy=1, out_data=0.
REQ-030 SHALL treat reset as dominant over simultaneous accept/pop; a read in flight during reset SHALL be discarded.
REQ-031 SHALL NOT clear memory contents on reset.

Structure
REQ-032 SHALL place default ADDR_WDTH/DATA_WDTH constants and the level width function in shared package dpbuf_pkg.
REQ-033 SHALL have exactly one sub-module, dpbuf_mem; the pointers, oq and flags SHALL be local to dpbuf_fifo.

Verification (ADDR_WDTH=4, DATA_WDTH=8)
REQ-034 SHALL cover: reset, then single write 0xA5 in cycle 0 with out_rdy=1 -> out_val=1 and out_data=0xA5 in cycle 3, then empty=1.
REQ-035 SHALL cover: out_rdy=0, write 0x00..0x11 continuously -> 18 accepted, in_rdy=0 after 16 in memory, level=18, 19th write dropped.
REQ-036 SHALL cover: from full, out_rdy=1 -> pops 0x00..0x11 in order, one per cycle, ending with level=0 and empty=1.
REQ-037 SHALL cover: in_val=1 and out_rdy=1 for 100 cycles with an incrementing pattern -> output order preserved, no gaps after latency, and pointer wrap exercised.
REQ-038 SHALL cover: random out_rdy backpressure -> out_data stable while stalled and the scoreboard matches.
REQ-039 SHALL cover: sync_reset asserted with level=7 and a read in flight -> next cycle level=0 and out_val=0, and no stale word is ever output.

Source files
------------

// File: rtl/dpbuf_pkg.sv
// Shared constants and helpers for the dual-port buffered FIFO.
package dpbuf_pkg;

    localparam int DEF_ADDR_WDTH = 4;
    localparam int DEF_DATA_WDTH = 8;

    // Width of the level output: it must hold MEM_SIZE + 2 (memory plus in-flight plus output stage).
    function automatic int level_wdth(input int addr_wdth);
        return addr_wdth + 2;
    endfunction

endpackage

// File: rtl/dpbuf_mem.sv
// Simple dual-port RAM with a registered read port (one cycle read latency).
// rd_dout_val marks the cycle in which rd_dout carries the word requested by rd_en.
module dpbuf_mem
    import dpbuf_pkg::*;
#(
    parameter int ADDR_WDTH = DEF_ADDR_WDTH,
    parameter int DATA_WDTH = DEF_DATA_WDTH
) (
    input  logic                 clk_wr,
    input  logic                 wr_en,
    input  logic [ADDR_WDTH-1:0] wr_addr,
    input  logic [DATA_WDTH-1:0] wr_data,
    input  logic                 clk_rd,
    input  logic                 rd_reset,
    input  logic                 rd_en,
    input  logic [ADDR_WDTH-1:0] rd_addr,
    output logic [DATA_WDTH-1:0] rd_dout,
    output logic                 rd_dout_val
);

    localparam int MEM_SIZE = 2 ** ADDR_WDTH;

    logic [DATA_WDTH-1:0] mem [MEM_SIZE];

    // Write port.
    // NOTE: the storage array has no reset; clearing it would cost a reset path per bit and the
    // pointers already make stale contents unreachable.
    always_ff @(posedge clk_wr) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read data.
    always_ff @(posedge clk_rd) begin
        if (rd_en) begin
            rd_dout <= mem[rd_addr];
        end
    end

    // Read-valid flag; cleared by reset so a read issued in the reset cycle is discarded.
    always_ff @(posedge clk_rd) begin
        if (rd_reset) begin
            rd_dout_val <= 1'b0;
        end else begin
            rd_dout_val <= rd_en;
        end
    end

endmodule

// File: rtl/dpbuf_fifo.sv
// Synchronous FIFO built on a registered-read RAM, with a 2-entry output queue that hides the
// read latency and keeps out_val/out_data registered. Sustains one word per cycle in and out.
module dpbuf_fifo
    import dpbuf_pkg::*;
#(
    parameter int ADDR_WDTH = DEF_ADDR_WDTH,
    parameter int DATA_WDTH = DEF_DATA_WDTH
) (
    input  logic                             clk,
    input  logic                             sync_reset,
    input  logic [DATA_WDTH-1:0]             in_data,
    input  logic                             in_val,
    output logic                             in_rdy,
    output logic [DATA_WDTH-1:0]             out_data,
    output logic                             out_val,
    input  logic                             out_rdy,
    output logic [level_wdth(ADDR_WDTH)-1:0] level,
    output logic                             empty
);

    localparam int MEM_SIZE = 2 ** ADDR_WDTH;
    localparam int PTR_W    = ADDR_WDTH + 1;
    localparam int LVL_W    = level_wdth(ADDR_WDTH);
    localparam logic [PTR_W-1:0] MEM_FULL = PTR_W'(MEM_SIZE);

    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     mem_count;
    logic                 inflight;
    logic [1:0]           oq_count;
    logic [DATA_WDTH-1:0] oq_head;
    logic [DATA_WDTH-1:0] oq_tail;
    logic [1:0]           oq_count_n;
    logic [DATA_WDTH-1:0] oq_head_n;
    logic [DATA_WDTH-1:0] oq_tail_n;
    logic [2:0]           oq_demand;
    logic                 accept;
    logic                 pop;
    logic                 rd_en;
    logic [DATA_WDTH-1:0] rd_dout;
    logic                 rd_dout_val;

    // The extra pointer bit distinguishes full from empty; the difference is the memory occupancy.
    assign mem_count = wr_ptr - rd_ptr;

    // in_rdy depends only on the pointers, so there is no path from out_rdy to in_rdy.
    assign in_rdy   = (mem_count != MEM_FULL);
    assign accept   = in_val && in_rdy;
    assign out_val  = (oq_count != 2'd0);
    assign out_data = oq_head;
    assign pop      = out_val && out_rdy;

    // Issue a read only when the output queue can take the word when it arrives next cycle.
    assign oq_demand = 3'(oq_count) + 3'(inflight) - 3'(pop);
    assign rd_en     = (mem_count != '0) && (oq_demand < 3'd2);

    assign level = LVL_W'(mem_count) + LVL_W'(inflight) + LVL_W'(oq_count);
    assign empty = (level == '0);

    dpbuf_mem #(
        .ADDR_WDTH(ADDR_WDTH),
        .DATA_WDTH(DATA_WDTH)
    ) u_mem (
        .clk_wr      (clk),
        .wr_en       (accept && !sync_reset),
        .wr_addr     (wr_ptr[ADDR_WDTH-1:0]),
        .wr_data     (in_data),
        .clk_rd      (clk),
        .rd_reset    (sync_reset),
        .rd_en       (rd_en && !sync_reset),
        .rd_addr     (rd_ptr[ADDR_WDTH-1:0]),
        .rd_dout     (rd_dout),
        .rd_dout_val (rd_dout_val)
    );

    // Pointer and in-flight bookkeeping; reset wins over any accept or read in the same cycle.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            inflight <= rd_en;
        end
    end

    // Output queue next state: pop shifts the tail to the head, then returning read data fills the first free slot.
    // NOTE: every output gets a default first so no path leaves a signal unassigned (no latch), and
    // blocking assignments let the push see the post-pop count within the same evaluation.
    always_comb begin
        oq_head_n  = oq_head;
        oq_tail_n  = oq_tail;
        oq_count_n = oq_count;
        if (pop) begin
            oq_head_n  = oq_tail;
            oq_count_n = oq_count - 2'd1;
        end
        if (rd_dout_val) begin
            if (oq_count_n == 2'd0) begin
                oq_head_n = rd_dout;
            end else begin
                oq_tail_n = rd_dout;
            end
            oq_count_n = oq_count_n + 2'd1;
        end
    end

    // Output queue registers; cleared on reset so out_data reads zero.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            oq_count <= 2'd0;
            oq_head  <= '0;
            oq_tail  <= '0;
        end else begin
            oq_count <= oq_count_n;
            oq_head  <= oq_head_n;
            oq_tail  <= oq_tail_n;
        end
    end

endmodule
